// File: rtl/biriscv_bpred_pkg.sv
// rtl/biriscv_bpred_pkg.sv - branch type encodings and counter constants for the branch predictor
package biriscv_bpred_defs;

    localparam logic [1:0] BR_TYPE_COND = 2'd0;
    localparam logic [1:0] BR_TYPE_JMP  = 2'd1;
    localparam logic [1:0] BR_TYPE_CALL = 2'd2;
    localparam logic [1:0] BR_TYPE_RET  = 2'd3;

    localparam logic [1:0] CTR_ALLOC = 2'b10;
    localparam logic [1:0] CTR_MAX   = 2'b11;

    // Call outranks ret, ret outranks jmp when several flags are raised together.
    function automatic logic [1:0] br_type_encode(input logic is_call,
                                                  input logic is_ret,
                                                  input logic is_jmp);
        if (is_call)
            return BR_TYPE_CALL;
        else if (is_ret)
            return BR_TYPE_RET;
        else if (is_jmp)
            return BR_TYPE_JMP;
        else
            return BR_TYPE_COND;
    endfunction

endpackage

// File: rtl/biriscv_bpred_ras.sv
// rtl/biriscv_bpred_ras.sv - circular return address stack updated at branch resolution
module biriscv_bpred_ras #(
    parameter int NUM_RAS_ENTRIES = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [31:0] i_push_pc,
    output logic [31:0] o_top_pc,
    output logic        o_valid
);

    localparam int PTR_W = $clog2(NUM_RAS_ENTRIES);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      r_stack [NUM_RAS_ENTRIES];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_top_inc;

    assign w_top_inc = r_top + 1'b1;

    // r_top indexes the live top entry; an overflowing push silently reuses the oldest slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_stack[w_top_inc] <= i_push_pc;
            r_top              <= w_top_inc;
            if (r_count != CNT_W'(NUM_RAS_ENTRIES))
                r_count <= r_count + 1'b1;
        end else if (i_pop && (r_count != '0)) begin
            r_top   <= r_top - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    assign o_top_pc = r_stack[r_top];
    assign o_valid  = (r_count != '0);

endmodule

// File: rtl/biriscv_bpred.sv
// rtl/biriscv_bpred.sv - fetch-stage branch predictor: fully-associative BTB with 2-bit counters plus RAS
module biriscv_bpred
    import biriscv_bpred_defs::*;
#(
    parameter int NUM_BTB_ENTRIES = 8,
    parameter int NUM_RAS_ENTRIES = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_f_i,
    input  logic        branch_request_i,
    input  logic        branch_is_taken_i,
    input  logic        branch_is_not_taken_i,
    input  logic [31:0] branch_source_i,
    input  logic [31:0] branch_pc_i,
    input  logic        branch_is_call_i,
    input  logic        branch_is_ret_i,
    input  logic        branch_is_jmp_i,
    output logic [31:0] next_pc_f_o,
    output logic        next_taken_f_o
);

    localparam int IDX_W = $clog2(NUM_BTB_ENTRIES);

    logic             r_valid  [NUM_BTB_ENTRIES];
    logic [29:0]      r_tag    [NUM_BTB_ENTRIES];
    logic [31:0]      r_target [NUM_BTB_ENTRIES];
    logic [1:0]       r_type   [NUM_BTB_ENTRIES];
    logic [1:0]       r_ctr    [NUM_BTB_ENTRIES];
    logic [IDX_W-1:0] r_repl_ptr;

    logic             w_hit;
    logic [IDX_W-1:0] w_hit_idx;
    logic             w_upd_hit;
    logic [IDX_W-1:0] w_upd_idx;
    logic             w_free;
    logic [IDX_W-1:0] w_free_idx;
    logic [IDX_W-1:0] w_alloc_idx;
    logic [1:0]       w_hit_type;
    logic             w_pred_taken;
    logic [31:0]      w_pred_target;
    logic             w_res_taken;
    logic             w_res_not_taken;
    logic [1:0]       w_upd_type;
    logic             w_ras_push;
    logic             w_ras_pop;
    logic [31:0]      w_ras_top;
    logic             w_ras_valid;

    // Fetch lookup, resolution lookup and lowest free slot are independent CAM searches.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_upd_hit  = 1'b0;
        w_upd_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
            if (r_valid[i] && (r_tag[i] == pc_f_i[31:2])) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (r_valid[i] && (r_tag[i] == branch_source_i[31:2])) begin
                w_upd_hit = 1'b1;
                w_upd_idx = IDX_W'(i);
            end
        end
        for (int i = NUM_BTB_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_hit_type    = r_type[w_hit_idx];
    assign w_pred_taken  = w_hit && ((w_hit_type != BR_TYPE_COND) || r_ctr[w_hit_idx][1]);
    assign w_pred_target = ((w_hit_type == BR_TYPE_RET) && w_ras_valid) ? w_ras_top
                                                                          : r_target[w_hit_idx];

    assign next_pc_f_o    = w_pred_taken ? w_pred_target : (pc_f_i + 32'd4);
    assign next_taken_f_o = w_pred_taken;

    assign w_res_taken     = branch_request_i & branch_is_taken_i;
    assign w_res_not_taken = branch_request_i & ~branch_is_taken_i & branch_is_not_taken_i;
    assign w_upd_type      = br_type_encode(branch_is_call_i, branch_is_ret_i, branch_is_jmp_i);
    assign w_alloc_idx     = w_free ? w_free_idx : r_repl_ptr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_BTB_ENTRIES; i++)
                r_valid[i] <= 1'b0;
            r_repl_ptr <= '0;
        end else if (w_res_taken) begin
            if (w_upd_hit) begin
                if (r_ctr[w_upd_idx] != CTR_MAX)
                    r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
                r_target[w_upd_idx] <= branch_pc_i;
                r_type[w_upd_idx]   <= w_upd_type;
            end else begin
                r_valid[w_alloc_idx]  <= 1'b1;
                r_tag[w_alloc_idx]    <= branch_source_i[31:2];
                r_target[w_alloc_idx] <= branch_pc_i;
                r_type[w_alloc_idx]   <= w_upd_type;
                r_ctr[w_alloc_idx]    <= CTR_ALLOC;
                if (!w_free)
                    r_repl_ptr <= r_repl_ptr + 1'b1;
            end
        end else if (w_res_not_taken && w_upd_hit) begin
            if (r_ctr[w_upd_idx] != 2'd0)
                r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
        end
    end

    assign w_ras_push = branch_request_i & branch_is_call_i;
    assign w_ras_pop  = branch_request_i & branch_is_ret_i & ~branch_is_call_i;

    biriscv_bpred_ras #(
        .NUM_RAS_ENTRIES(NUM_RAS_ENTRIES)
    ) u_ras (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_push   (w_ras_push),
        .i_pop    (w_ras_pop),
        .i_push_pc(branch_source_i + 32'd4),
        .o_top_pc (w_ras_top),
        .o_valid  (w_ras_valid)
    );

endmodule
